// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the shared datapath (slave).
interface multi_cycle_ctrl_if;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ST_W    = 3;
  localparam int unsigned ALUOP_W = 3;

  logic [OP_W-1:0]    op;
  logic               zero;
  logic               PCWre;
  logic [1:0]         PCSrc;
  logic               IRWre;
  logic               InsMemRW;
  logic               ALUSrcA;
  logic               ALUSrcB;
  logic               ExtSel;
  logic [ALUOP_W-1:0] ALUOp;
  logic               mRD;
  logic               mWR;
  logic               DBDataSrc;
  logic [1:0]         RegDst;
  logic               WrRegDSrc;
  logic               RegWre;
  logic [ST_W-1:0]    state;
  logic               halted;
  logic               illegal;

  modport master (
    input  op, zero,
    output PCWre, PCSrc, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
           mRD, mWR, DBDataSrc, RegDst, WrRegDSrc, RegWre, state, halted, illegal
  );

  modport slave (
    output op, zero,
    input  PCWre, PCSrc, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
           mRD, mWR, DBDataSrc, RegDst, WrRegDSrc, RegWre, state, halted, illegal
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer driving every datapath enable and mux select.
// Outputs decode combinationally from the state and the opcode captured on entry to ID.
module multi_cycle_ctrl #(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic                clk,
  input  logic                Reset,
  multi_cycle_ctrl_if.master  bus
);
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ST_W    = 3;
  localparam int unsigned ALUOP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [OP_W-1:0] OP_OR   = 6'b010000;
  localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b010010;
  localparam logic [OP_W-1:0] OP_SLL  = 6'b011000;
  localparam logic [OP_W-1:0] OP_SLT  = 6'b100110;
  localparam logic [OP_W-1:0] OP_SW   = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b110101;
  localparam logic [OP_W-1:0] OP_J    = 6'b111000;
  localparam logic [OP_W-1:0] OP_JR   = 6'b111001;
  localparam logic [OP_W-1:0] OP_JAL  = 6'b111010;

  typedef enum logic [ST_W-1:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [OP_W-1:0]   op_q;

  logic               is_rtype, is_imm_b, is_br, is_jmp, is_legal, is_halt;
  logic [ALUOP_W-1:0] alu_fn;

  logic               pc_wre, ir_wre, ins_mem_rw, alu_src_a, alu_src_b, ext_sel;
  logic               m_rd, m_wr, db_data_src, wr_reg_d_src, reg_wre, halted, illegal;
  logic [1:0]         pc_src, reg_dst;
  logic [ALUOP_W-1:0] alu_op;

  // State register; the opcode is captured on the IF->ID edge alongside the IR load.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IF;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IF) op_q <= bus.op;
    end
  end

  // Opcode classification and ALU function.
  always_comb begin
    is_rtype = 1'b0;
    is_imm_b = 1'b0;
    is_br    = 1'b0;
    is_jmp   = 1'b0;
    is_legal = 1'b1;
    alu_fn   = 3'b000;
    is_halt  = (op_q == HALT_OP);
    case (op_q)
      OP_ADD:  begin is_rtype = 1'b1; alu_fn = 3'b000; end
      OP_SUB:  begin is_rtype = 1'b1; alu_fn = 3'b001; end
      OP_OR:   begin is_rtype = 1'b1; alu_fn = 3'b011; end
      OP_AND:  begin is_rtype = 1'b1; alu_fn = 3'b100; end
      OP_SLL:  begin is_rtype = 1'b1; alu_fn = 3'b010; end
      OP_SLT:  begin is_rtype = 1'b1; alu_fn = 3'b101; end
      OP_ADDI: begin is_imm_b = 1'b1; alu_fn = 3'b000; end
      OP_ORI:  begin is_imm_b = 1'b1; alu_fn = 3'b011; end
      OP_SW:   begin is_imm_b = 1'b1; alu_fn = 3'b000; end
      OP_LW:   begin is_imm_b = 1'b1; alu_fn = 3'b000; end
      OP_BEQ:  begin is_br    = 1'b1; alu_fn = 3'b001; end
      OP_BNE:  begin is_br    = 1'b1; alu_fn = 3'b001; end
      OP_J:    is_jmp = 1'b1;
      OP_JR:   is_jmp = 1'b1;
      OP_JAL:  is_jmp = 1'b1;
      default: is_legal = 1'b0;
    endcase
  end

  // Next state and control outputs.
  always_comb begin
    state_d      = state_q;
    pc_wre       = 1'b0;
    pc_src       = 2'b00;
    ir_wre       = 1'b0;
    ins_mem_rw   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    ext_sel      = 1'b0;
    alu_op       = 3'b000;
    m_rd         = 1'b0;
    m_wr         = 1'b0;
    db_data_src  = 1'b0;
    reg_dst      = 2'b00;
    wr_reg_d_src = 1'b0;
    reg_wre      = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;

    // Mux selects are meaningful only once the opcode is captured.
    if (state_q != S_IF && state_q != S_HALT) begin
      alu_src_a    = (op_q == OP_SLL);
      alu_src_b    = is_imm_b;
      ext_sel      = (op_q != OP_ORI);
      alu_op       = alu_fn;
      reg_dst      = (op_q == OP_JAL) ? 2'b10 : (is_rtype ? 2'b01 : 2'b00);
      wr_reg_d_src = (op_q == OP_JAL);
    end

    case (state_q)
      S_IF: begin
        ir_wre     = 1'b1;
        ins_mem_rw = 1'b1;
        state_d    = S_ID;
      end
      S_ID: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (!is_legal) begin
          illegal = 1'b1;
          pc_wre  = 1'b1;
          state_d = S_IF;
        end else if (is_jmp) begin
          pc_wre  = 1'b1;
          pc_src  = (op_q == OP_JR) ? 2'b10 : 2'b11;
          reg_wre = (op_q == OP_JAL);
          state_d = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_br) begin
          pc_wre  = 1'b1;
          pc_src  = (((op_q == OP_BEQ) ? bus.zero : !bus.zero)) ? 2'b01 : 2'b00;
          state_d = S_IF;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (op_q == OP_SW) begin
          m_wr    = 1'b1;
          pc_wre  = 1'b1;
          state_d = S_IF;
        end else begin
          m_rd    = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_wre     = 1'b1;
        pc_wre      = 1'b1;
        db_data_src = (op_q == OP_LW);
        state_d     = S_IF;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IF;
    endcase
  end

  // Reset gates every output so nothing reaches the datapath while it is held.
  always_comb begin
    bus.PCWre     = Reset & pc_wre;
    bus.PCSrc     = Reset ? pc_src : 2'b00;
    bus.IRWre     = Reset & ir_wre;
    bus.InsMemRW  = Reset & ins_mem_rw;
    bus.ALUSrcA   = Reset & alu_src_a;
    bus.ALUSrcB   = Reset & alu_src_b;
    bus.ExtSel    = Reset & ext_sel;
    bus.ALUOp     = Reset ? alu_op : 3'b000;
    bus.mRD       = Reset & m_rd;
    bus.mWR       = Reset & m_wr;
    bus.DBDataSrc = Reset & db_data_src;
    bus.RegDst    = Reset ? reg_dst : 2'b00;
    bus.WrRegDSrc = Reset & wr_reg_d_src;
    bus.RegWre    = Reset & reg_wre;
    bus.state     = Reset ? state_q : 3'b000;
    bus.halted    = Reset & halted;
    bus.illegal   = Reset & illegal;
  end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Random instruction stream against a per-instruction phase/latency model of the sequencer.
module tb_multi_cycle_ctrl;
  localparam int unsigned N_RAND = 300;
  localparam logic [5:0] HALT = 6'b111111;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010, OR_ = 6'b010000;
  localparam logic [5:0] AND_ = 6'b010001, ORI = 6'b010010, SLL = 6'b011000, SLT = 6'b100110;
  localparam logic [5:0] SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100, BNE = 6'b110101;
  localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010;
  localparam logic [5:0] LEGAL_OPS [15] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT,
                                            SW, LW, BEQ, BNE, J, JR, JAL};

  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_JMP = 4, K_ILL = 5;
  localparam logic [2:0] P_IF = 3'd0, P_ID = 3'd1, P_EXE = 3'd2, P_MEM = 3'd3, P_WB = 3'd4, P_HALT = 3'd5;

  logic clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_errors = 0;

  multi_cycle_ctrl_if bus();
  multi_cycle_ctrl #(.HALT_OP(HALT)) dut (.clk(clk), .Reset(Reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int kind_of(input logic [5:0] o);
    case (o)
      ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT: return K_ALU;
      LW:  return K_LW;
      SW:  return K_SW;
      BEQ, BNE: return K_BR;
      J, JR, JAL: return K_JMP;
      default: return K_ILL;
    endcase
  endfunction

  function automatic int len_of(input int k);
    case (k)
      K_LW: return 5;
      K_SW, K_ALU: return 4;
      K_BR: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] phase_of(input int k, input int c);
    logic [2:0] seq [5];
    case (k)
      K_LW:  seq = '{P_IF, P_ID, P_EXE, P_MEM, P_WB};
      K_SW:  seq = '{P_IF, P_ID, P_EXE, P_MEM, P_IF};
      K_ALU: seq = '{P_IF, P_ID, P_EXE, P_WB, P_IF};
      K_BR:  seq = '{P_IF, P_ID, P_EXE, P_IF, P_IF};
      default: seq = '{P_IF, P_ID, P_IF, P_IF, P_IF};
    endcase
    return seq[c];
  endfunction

  function automatic logic [2:0] alu_fn_of(input logic [5:0] o);
    case (o)
      SUB, BEQ, BNE: return 3'b001;
      SLL: return 3'b010;
      OR_, ORI: return 3'b011;
      AND_: return 3'b100;
      SLT: return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] obs_all();
    return 32'({bus.state, bus.PCWre, bus.PCSrc, bus.IRWre, bus.InsMemRW, bus.ALUSrcA,
                bus.ALUSrcB, bus.ExtSel, bus.ALUOp, bus.mRD, bus.mWR, bus.DBDataSrc,
                bus.RegDst, bus.WrRegDSrc, bus.RegWre, bus.halted, bus.illegal});
  endfunction

  function automatic logic [7:0] obs_en();
    return {bus.PCWre, bus.IRWre, bus.InsMemRW, bus.mRD, bus.mWR, bus.RegWre, bus.halted, bus.illegal};
  endfunction

  // One instruction; zexe >= 0 forces zero in EXE, abort_mem asserts reset inside MEM.
  task automatic run_instr(input logic [5:0] o, input int zexe, input bit abort_mem);
    int k;
    int n;
    k = kind_of(o);
    n = len_of(k);
    for (int c = 0; c < n; c++) begin
      logic [2:0] ph;
      logic       last, z, regw, taken;
      logic [1:0] exp_pcsrc, exp_dst;
      logic [7:0] exp_en;
      @(negedge clk);
      ph      = phase_of(k, c);
      bus.op  = (c == 0) ? o : 6'($urandom);
      z       = 1'($urandom);
      if (ph == P_EXE && zexe >= 0) z = zexe[0];
      bus.zero = z;
      #1;
      last  = (c == n - 1);
      regw  = (last && (k == K_ALU || k == K_LW)) || (o == JAL && c == 1);
      taken = (o == BEQ) ? z : !z;
      exp_en = {last, c == 0, c == 0, k == K_LW && ph == P_MEM, k == K_SW && ph == P_MEM,
                regw, 1'b0, k == K_ILL && c == 1};
      check("state", 32'(bus.state), 32'(ph));
      check("enables", 32'(obs_en()), 32'(exp_en));
      if (last) begin
        if (o == JR) exp_pcsrc = 2'b10;
        else if (o == J || o == JAL) exp_pcsrc = 2'b11;
        else if (k == K_BR && taken) exp_pcsrc = 2'b01;
        else exp_pcsrc = 2'b00;
        check("pcsrc", 32'(bus.PCSrc), 32'(exp_pcsrc));
      end
      if (ph == P_EXE)
        check("alu_ctl", 32'({bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel, bus.ALUOp}),
              32'({o == SLL, o == ADDI || o == ORI || o == LW || o == SW, o != ORI, alu_fn_of(o)}));
      if (regw) begin
        exp_dst = (o == JAL) ? 2'b10 : ((k == K_ALU && o != ADDI && o != ORI) ? 2'b01 : 2'b00);
        check("wb_sel", 32'({bus.RegDst, bus.WrRegDSrc, bus.DBDataSrc}),
              32'({exp_dst, o == JAL, o == LW}));
      end
      if (abort_mem && ph == P_MEM) begin
        Reset = 1'b0;
        #1;
        check("abort_all", obs_all(), 32'd0);
        @(posedge clk);
        #2;
        Reset = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_halt();
    for (int c = 0; c < 12; c++) begin
      logic [2:0] exp_st;
      @(negedge clk);
      bus.op   = (c == 0) ? HALT : 6'($urandom);
      bus.zero = 1'($urandom);
      #1;
      exp_st = (c == 0) ? P_IF : ((c == 1) ? P_ID : P_HALT);
      check("halt_state", 32'(bus.state), 32'(exp_st));
      check("halt_en", 32'(obs_en()), 32'({1'b0, c == 0, c == 0, 3'b000, c >= 2, 1'b0}));
    end
  endtask

  initial begin
    logic [5:0] o;
    Reset    = 1'b0;
    bus.op   = 6'b000000;
    bus.zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bus.zero = 1'($urandom);
      #1;
      check("reset_all", obs_all(), 32'd0);
    end
    @(posedge clk);
    #2;
    Reset = 1'b1;

    run_instr(ADD, -1, 1'b0);
    run_instr(LW, -1, 1'b0);
    run_instr(SW, -1, 1'b0);
    run_instr(BEQ, 1, 1'b0);
    run_instr(BNE, 1, 1'b0);
    run_instr(BEQ, 0, 1'b0);
    run_instr(BNE, 0, 1'b0);
    run_instr(JAL, -1, 1'b0);
    run_instr(J, -1, 1'b0);
    run_instr(JR, -1, 1'b0);
    run_instr(6'b101010, -1, 1'b0);
    run_instr(SLL, -1, 1'b0);
    run_instr(ORI, -1, 1'b0);

    for (int i = 0; i < int'(N_RAND); i++) begin
      if ($urandom_range(9) < 7) o = LEGAL_OPS[$urandom_range(14)];
      else begin
        o = 6'($urandom);
        if (o == HALT) o = 6'b101010;
      end
      run_instr(o, -1, 1'b0);
    end

    run_instr(LW, -1, 1'b1);
    run_instr(ADD, -1, 1'b0);
    run_halt();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
